// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: shift source and shift kind selectors used by
// the operand-2 barrel shifter and its neighbours.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    LSL = 2'd0,
    LSR = 2'd1,
    ASR = 2'd2,
    ROR = 2'd3
  } shift_type_t;

  typedef enum logic [1:0] {
    SRC_IMM_ROT = 2'd0,
    SRC_REG_IMM = 2'd1,
    SRC_REG_REG = 2'd2
  } shift_src_t;

  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/barrel_shifter_if.sv
// Operand-2 request/result bundle between the decode stage (master) and the
// barrel shifter (slave).
interface barrel_shifter_if import cpu_types_pkg::*; ();

  logic              start;
  shift_src_t        shift_src;
  shift_type_t       shift_type;
  logic [4:0]        imm_amount;
  logic [7:0]        imm8;
  logic [3:0]        rot4;
  logic [WORD_W-1:0] rm_value;
  logic [WORD_W-1:0] rs_value;
  logic              carry_in;
  logic [WORD_W-1:0] op_b;
  logic              carry_out;
  logic              busy;
  logic              valid;

  modport master (
    output start, shift_src, shift_type, imm_amount, imm8, rot4,
           rm_value, rs_value, carry_in,
    input  op_b, carry_out, busy, valid
  );

  modport slave (
    input  start, shift_src, shift_type, imm_amount, imm8, rot4,
           rm_value, rs_value, carry_in,
    output op_b, carry_out, busy, valid
  );

endinterface

// File: rtl/barrel_shift_core.sv
// Combinational ARM shifter: one shift of a 32-bit value by an 8-bit amount,
// with the immediate-encoding (#0 = #32 / RRX) or register-encoding rules.
module barrel_shift_core
  import cpu_types_pkg::*;
(
  input  shift_type_t       shift_type,
  input  logic [7:0]        amount,
  input  logic              amount_is_imm,
  input  logic [WORD_W-1:0] value,
  input  logic              carry_in,
  output logic [WORD_W-1:0] result,
  output logic              carry
);

  logic [4:0]        n;
  logic              amount_big;
  logic              amount_is_32;
  logic [WORD_W:0]   wide_l;
  logic [WORD_W:0]   wide_r;
  logic [WORD_W:0]   wide_a;
  logic [WORD_W-1:0] rot_val;

  // The extra bit of each 33-bit shift catches the last bit shifted out,
  // which is the carry for every in-range amount.
  assign n            = amount[4:0];
  assign amount_big   = |amount[7:5];
  assign amount_is_32 = (amount == 8'd32);
  assign wide_l       = {1'b0, value} << n;
  assign wide_r       = {value, 1'b0} >> n;
  assign wide_a       = $signed({value, 1'b0}) >>> n;
  assign rot_val      = (value >> n) | (value << (6'd32 - {1'b0, n}));

  always_comb begin
    result = value;
    carry  = carry_in;
    if (amount_is_imm) begin
      unique case (shift_type)
        LSL: if (n != 5'd0) {carry, result} = wide_l;
        LSR: begin
          if (n == 5'd0) begin
            result = '0;
            carry  = value[31];
          end else begin
            {result, carry} = wide_r;
          end
        end
        ASR: begin
          if (n == 5'd0) begin
            result = {WORD_W{value[31]}};
            carry  = value[31];
          end else begin
            {result, carry} = wide_a;
          end
        end
        ROR: begin
          if (n == 5'd0) begin
            result = {carry_in, value[31:1]};
            carry  = value[0];
          end else begin
            result = rot_val;
            carry  = rot_val[31];
          end
        end
        default: ;
      endcase
    end else if (amount != 8'd0) begin
      // Register amounts of 32 and above are resolved here, never by a shift.
      unique case (shift_type)
        LSL: begin
          if (!amount_big) begin
            {carry, result} = wide_l;
          end else begin
            result = '0;
            carry  = amount_is_32 ? value[0] : 1'b0;
          end
        end
        LSR: begin
          if (!amount_big) begin
            {result, carry} = wide_r;
          end else begin
            result = '0;
            carry  = amount_is_32 ? value[31] : 1'b0;
          end
        end
        ASR: begin
          if (!amount_big) begin
            {result, carry} = wide_a;
          end else begin
            result = {WORD_W{value[31]}};
            carry  = value[31];
          end
        end
        ROR: begin
          if (n == 5'd0) begin
            result = value;
            carry  = value[31];
          end else begin
            result = rot_val;
            carry  = rot_val[31];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter.sv
// Operand-2 stage: one-cycle immediate forms, two-cycle register-amount form,
// registered op_b/carry_out held for the ALU between valid pulses.
module barrel_shifter
  import cpu_types_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  barrel_shifter_if.slave    bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        state;
  logic [WORD_W-1:0] lat_value;
  logic [7:0]        lat_amount;
  shift_type_t       lat_type;
  logic              lat_carry;

  shift_type_t       core_type;
  logic [7:0]        core_amount;
  logic              core_is_imm;
  logic [WORD_W-1:0] core_value;
  logic              core_cin;
  logic [WORD_W-1:0] core_result;
  logic              core_carry;

  wire unused_rs_high = ^bus.rs_value[31:8];

  // A single core serves both paths: live inputs in IDLE, latches in SHIFT.
  // The immediate rotate is a register-style ROR by 2*rot4, whose amount-0
  // case already yields the unrotated value with the incoming carry.
  always_comb begin
    core_type   = lat_type;
    core_amount = lat_amount;
    core_is_imm = 1'b0;
    core_value  = lat_value;
    core_cin    = lat_carry;
    if (state == ST_IDLE) begin
      unique case (bus.shift_src)
        SRC_IMM_ROT: begin
          core_type   = ROR;
          core_amount = {3'b000, bus.rot4, 1'b0};
          core_value  = {24'd0, bus.imm8};
          core_cin    = bus.carry_in;
        end
        SRC_REG_IMM: begin
          core_type   = bus.shift_type;
          core_amount = {3'b000, bus.imm_amount};
          core_is_imm = 1'b1;
          core_value  = bus.rm_value;
          core_cin    = bus.carry_in;
        end
        default: ;
      endcase
    end
  end

  barrel_shift_core u_core (
    .shift_type    (core_type),
    .amount        (core_amount),
    .amount_is_imm (core_is_imm),
    .value         (core_value),
    .carry_in      (core_cin),
    .result        (core_result),
    .carry         (core_carry)
  );

  // FSM, operand latches and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      lat_value     <= '0;
      lat_amount    <= '0;
      lat_type      <= LSL;
      lat_carry     <= 1'b0;
      bus.op_b      <= '0;
      bus.carry_out <= 1'b0;
      bus.valid     <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.shift_src == SRC_REG_REG) begin
              lat_value  <= bus.rm_value;
              lat_amount <= bus.rs_value[7:0];
              lat_type   <= bus.shift_type;
              lat_carry  <= bus.carry_in;
              state      <= ST_SHIFT;
            end else if (bus.shift_src == SRC_IMM_ROT ||
                         bus.shift_src == SRC_REG_IMM) begin
              bus.op_b      <= core_result;
              bus.carry_out <= core_carry;
              bus.valid     <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          bus.op_b      <= core_result;
          bus.carry_out <= core_carry;
          bus.valid     <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_barrel_shifter.sv
// Randomised and directed bench for barrel_shifter against a bit-serial
// reference model of the ARM operand-2 rules.
module tb_barrel_shifter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  barrel_shifter_if bus ();

  barrel_shifter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register-specified shift by k (0..255); returns {carry, result}.
  function automatic logic [32:0] reg_shift(shift_type_t typ, int k,
                                            logic [31:0] rm, logic cin);
    logic [63:0]        w;
    logic signed [63:0] s;
    logic [31:0]        r;
    if (k == 0) return {cin, rm};
    case (typ)
      LSL: begin
        w = {32'd0, rm};
        w = (k <= 32) ? (w << k) : 64'd0;
        return {w[32], w[31:0]};
      end
      LSR: begin
        if (k > 32) return 33'd0;
        w = {rm, 32'd0} >> k;
        return {w[31], w[63:32]};
      end
      ASR: begin
        s = {rm, 32'd0};
        s = s >>> ((k > 32) ? 32 : k);
        return {s[31], s[63:32]};
      end
      default: begin
        r = rm;
        for (int i = 0; i < k; i++) r = {r[0], r[31:1]};
        return {r[31], r};
      end
    endcase
  endfunction

  function automatic logic [32:0] model(shift_src_t src, shift_type_t typ,
                                        logic [4:0] ia, logic [7:0] i8,
                                        logic [3:0] r4, logic [31:0] rm,
                                        logic [31:0] rs, logic cin);
    logic [31:0] r;
    case (src)
      SRC_IMM_ROT: begin
        r = {24'd0, i8};
        for (int i = 0; i < 2 * r4; i++) r = {r[0], r[31:1]};
        return {(r4 == 4'd0) ? cin : r[31], r};
      end
      SRC_REG_IMM: begin
        if (ia != 5'd0) return reg_shift(typ, int'(ia), rm, cin);
        case (typ)
          LSL:     return {cin, rm};
          LSR:     return reg_shift(LSR, 32, rm, cin);
          ASR:     return reg_shift(ASR, 32, rm, cin);
          default: return {rm[0], cin, rm[31:1]};
        endcase
      end
      default: return reg_shift(typ, int'(rs[7:0]), rm, cin);
    endcase
  endfunction

  // Drives one request, scrambles the operands after the start edge, and
  // reports the result and the number of edges until valid (0 = timeout).
  task automatic send(input shift_src_t src, input shift_type_t typ,
                      input logic [4:0] ia, input logic [7:0] i8,
                      input logic [3:0] r4, input logic [31:0] rm,
                      input logic [31:0] rs, input logic cin,
                      output logic [31:0] op, output logic c,
                      output int lat, output logic busy1);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.shift_src  = src;
    bus.shift_type = typ;
    bus.imm_amount = ia;
    bus.imm8       = i8;
    bus.rot4       = r4;
    bus.rm_value   = rm;
    bus.rs_value   = rs;
    bus.carry_in   = cin;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    busy1          = bus.busy;
    bus.rm_value   = $urandom;
    bus.rs_value   = $urandom;
    bus.carry_in   = 1'($urandom);
    bus.shift_type = shift_type_t'($urandom_range(0, 3));
    lat = 0;
    op  = 'x;
    c   = 1'bx;
    for (int i = 1; i <= 4; i++) begin
      if (bus.valid === 1'b1) begin
        lat = i;
        op  = bus.op_b;
        c   = bus.carry_out;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.shift_src  = SRC_IMM_ROT;
    bus.shift_type = LSL;
    bus.imm_amount = '0;
    bus.imm8       = '0;
    bus.rot4       = '0;
    bus.rm_value   = '0;
    bus.rs_value   = '0;
    bus.carry_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.op_b !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_op_b got=%h want=0", bus.op_b);
    end
    checks++;
    if (bus.carry_out !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_carry got=%b want=0", bus.carry_out);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid got=%b want=0", bus.valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy);
    end
    reset = 1'b0;
  endtask

  typedef struct {
    shift_src_t  src;
    shift_type_t typ;
    logic [4:0]  ia;
    logic [7:0]  i8;
    logic [3:0]  r4;
    logic [31:0] rm;
    logic [31:0] rs;
    logic        cin;
    logic [31:0] exp_op;
    logic        exp_c;
  } vec_t;

  task automatic test_directed();
    vec_t        v[8];
    logic [31:0] op;
    logic        c, busy1;
    int          lat;
    v[0] = '{SRC_REG_IMM, LSL, 5'd4, 8'h00, 4'd0, 32'h1000_000F, 32'h0, 1'b0, 32'h0000_00F0, 1'b1};
    v[1] = '{SRC_REG_IMM, ROR, 5'd0, 8'h00, 4'd0, 32'h0000_0003, 32'h0, 1'b1, 32'h8000_0001, 1'b1};
    v[2] = '{SRC_REG_REG, LSR, 5'd0, 8'h00, 4'd0, 32'h8000_0000, 32'h120, 1'b0, 32'h0, 1'b1};
    v[3] = '{SRC_REG_REG, LSR, 5'd0, 8'h00, 4'd0, 32'h8000_0000, 32'h21, 1'b1, 32'h0, 1'b0};
    v[4] = '{SRC_REG_REG, ROR, 5'd0, 8'h00, 4'd0, 32'h8000_0001, 32'h40, 1'b0, 32'h8000_0001, 1'b1};
    v[5] = '{SRC_REG_REG, ROR, 5'd0, 8'h00, 4'd0, 32'h8000_0001, 32'h0, 1'b0, 32'h8000_0001, 1'b0};
    v[6] = '{SRC_IMM_ROT, LSL, 5'd0, 8'hFF, 4'd4, 32'h0, 32'h0, 1'b0, 32'hFF00_0000, 1'b1};
    v[7] = '{SRC_IMM_ROT, LSL, 5'd0, 8'hFF, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0000_00FF, 1'b0};
    for (int i = 0; i < 8; i++) begin
      send(v[i].src, v[i].typ, v[i].ia, v[i].i8, v[i].r4, v[i].rm, v[i].rs,
           v[i].cin, op, c, lat, busy1);
      checks++;
      if (lat !== ((v[i].src == SRC_REG_REG) ? 2 : 1)) begin
        errors++; $display("[TB] FAIL dir%0d_latency got=%0d", i, lat);
      end
      checks++;
      if (busy1 !== (v[i].src == SRC_REG_REG)) begin
        errors++; $display("[TB] FAIL dir%0d_busy got=%b", i, busy1);
      end
      checks++;
      if (op !== v[i].exp_op) begin
        errors++; $display("[TB] FAIL dir%0d_op_b got=%h want=%h", i, op, v[i].exp_op);
      end
      checks++;
      if (c !== v[i].exp_c) begin
        errors++; $display("[TB] FAIL dir%0d_carry got=%b want=%b", i, c, v[i].exp_c);
      end
    end
  endtask

  task automatic test_random();
    shift_src_t  src;
    shift_type_t typ;
    logic [4:0]  ia;
    logic [7:0]  i8, amt;
    logic [3:0]  r4;
    logic [31:0] rm, rs, op;
    logic        cin, c, busy1;
    logic [32:0] exp;
    int          lat;
    for (int t = 0; t < 120; t++) begin
      src = shift_src_t'($urandom_range(0, 2));
      typ = shift_type_t'($urandom_range(0, 3));
      ia  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      i8  = 8'($urandom);
      r4  = 4'($urandom);
      rm  = $urandom;
      cin = 1'($urandom);
      case ($urandom_range(0, 7))
        0: amt = 8'd0;
        1: amt = 8'd1;
        2: amt = 8'd31;
        3: amt = 8'd32;
        4: amt = 8'd33;
        5: amt = 8'd64;
        6: amt = 8'd255;
        default: amt = 8'($urandom);
      endcase
      rs  = {24'($urandom), amt};
      exp = model(src, typ, ia, i8, r4, rm, rs, cin);
      send(src, typ, ia, i8, r4, rm, rs, cin, op, c, lat, busy1);
      checks++;
      if (lat !== ((src == SRC_REG_REG) ? 2 : 1)) begin
        errors++; $display("[TB] FAIL rnd%0d_latency src=%0d got=%0d", t, src, lat);
      end
      checks++;
      if (op !== exp[31:0] || c !== exp[32]) begin
        errors++;
        $display("[TB] FAIL rnd%0d_result src=%0d typ=%0d ia=%0d amt=%0d rm=%h got=%b/%h want=%b/%h",
                 t, src, typ, ia, amt, rm, c, op, exp[32], exp[31:0]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.valid !== 1'b0 || bus.op_b !== exp[31:0] || bus.carry_out !== exp[32]) begin
        errors++;
        $display("[TB] FAIL rnd%0d_hold valid=%b got=%b/%h want=%b/%h",
                 t, bus.valid, bus.carry_out, bus.op_b, exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_start_during_shift();
    logic [31:0] rm;
    logic [32:0] exp;
    int          nvalid;
    rm  = $urandom;
    exp = model(SRC_REG_REG, LSL, 5'd0, 8'd0, 4'd0, rm, 32'd4, 1'b0);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.shift_src  = SRC_REG_REG;
    bus.shift_type = LSL;
    bus.rm_value   = rm;
    bus.rs_value   = 32'd4;
    bus.carry_in   = 1'b0;
    @(posedge clk);
    #1;
    bus.shift_src  = SRC_REG_IMM;
    bus.shift_type = ROR;
    bus.imm_amount = 5'd7;
    bus.rm_value   = ~rm;
    nvalid = 0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (bus.valid === 1'b1) begin
      nvalid++;
      checks++;
      if (bus.op_b !== exp[31:0] || bus.carry_out !== exp[32]) begin
        errors++;
        $display("[TB] FAIL ignore_start_result got=%b/%h want=%b/%h",
                 bus.carry_out, bus.op_b, exp[32], exp[31:0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid !== 1) begin
      errors++; $display("[TB] FAIL ignore_start_valid_count got=%0d want=1", nvalid);
    end
  endtask

  task automatic test_reset_in_shift();
    logic [31:0] op;
    logic        c, busy1;
    int          lat, nvalid;
    send(SRC_REG_IMM, LSL, 5'd0, 8'd0, 4'd0, 32'hDEAD_BEEF, 32'd0, 1'b1, op, c, lat, busy1);
    checks++;
    if (op !== 32'hDEAD_BEEF || c !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_result got=%b/%h want=1/deadbeef", c, op);
    end
    @(negedge clk);
    bus.start     = 1'b1;
    bus.shift_src = SRC_REG_REG;
    bus.rs_value  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_shift_busy_before got=%b want=1", bus.busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_shift_flags busy=%b valid=%b want=0/0", bus.busy, bus.valid);
    end
    checks++;
    if (bus.op_b !== 32'd0 || bus.carry_out !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_shift_outputs got=%b/%h want=0/0", bus.carry_out, bus.op_b);
    end
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid !== 0) begin
      errors++; $display("[TB] FAIL rst_shift_late_valid got=%0d want=0", nvalid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_shift();
    test_reset_in_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barrel_shifter.md
# barrel_shifter

Operand-2 stage of the GBA CPU datapath, directly upstream of the ALU. It produces the ALU's `op_b` and shifter carry-out from one of three operand forms:
- an 8-bit immediate rotated right by an even amount;
- a register shifted by a 5-bit immediate;
- a register shifted by the low byte of a second register.

Register-specified shifts take two cycles, one to latch the amount and one to shift, matching the ARM7TDMI internal cycle. Outputs are registered and held until the next result.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `shift_src`  in  `shift_src_t`(2)  `SRC_IMM_ROT`, `SRC_REG_IMM`, `SRC_REG_REG`
- `shift_type`  in  `shift_type_t`(2)  `LSL`, `LSR`, `ASR`, `ROR`
- `imm_amount`  in  5  shift amount for `SRC_REG_IMM`
- `imm8`  in  8  immediate value for `SRC_IMM_ROT`
- `rot4`  in  4  rotate field; rotate amount = 2×`rot4`
- `rm_value`  in  32  register operand to be shifted
- `rs_value`  in  32  shift-amount register; only bits [7:0] are used
- `carry_in`  in  1  CPSR C flag
- `op_b`  out  32  shifted operand, fed to the ALU
- `carry_out`  out  1  shifter carry, fed to the ALU
- `busy`  out  1  state ≠ IDLE
- `valid`  out  1  one-cycle pulse when `op_b`/`carry_out` update

## Operation
State machine: IDLE, SHIFT.
- IDLE + `start` with an immediate form (`SRC_IMM_ROT` or `SRC_REG_IMM`):
  - compute from live inputs;
  - register `op_b`/`carry_out`, set `valid`;
  - stay in IDLE.
- IDLE + `start` with `SRC_REG_REG`:
  - latch `rm_value`, `rs_value[7:0]`, `shift_type` and `carry_in`;
  - go to SHIFT.
- SHIFT: compute from the latched values, register the outputs, set `valid`, return to IDLE.
- `start` while in SHIFT is ignored (no queueing). `start` is accepted in the same cycle that `valid` is high, because the block is already back in IDLE.

`SRC_IMM_ROT`, with rot = 2×`rot4`:
- rot = 0: `op_b` = zero-extended `imm8`, C = `carry_in`.
- otherwise: `op_b` = ror(imm8, rot), C = `op_b[31]`.

`SRC_REG_IMM`, with n = `imm_amount`:
- LSL:
  - n = 0: `op_b` = rm, C = `carry_in`.
  - n > 0: `op_b` = rm<<n, C = rm[32-n].
- LSR:
  - n = 0 means LSR #32: `op_b` = 0, C = rm[31].
  - n > 0: `op_b` = rm>>n, C = rm[n-1].
- ASR:
  - n = 0 means ASR #32: `op_b` = {32{rm[31]}}, C = rm[31].
  - n > 0: arithmetic shift, C = rm[n-1].
- ROR:
  - n = 0 means RRX: `op_b` = {`carry_in`, rm[31:1]}, C = rm[0].
  - n > 0: rotate, C = rm[n-1].

`SRC_REG_REG`, with amt = `rs[7:0]` (0..255):
- amt = 0, any type: `op_b` = rm, C = `carry_in`.
- LSL:
  - 1–31: normal shift.
  - 32: `op_b` = 0, C = rm[0].
  - >32: `op_b` = 0, C = 0.
- LSR:
  - 1–31: normal shift.
  - 32: `op_b` = 0, C = rm[31].
  - >32: `op_b` = 0, C = 0.
- ASR: amt ≥ 32: `op_b` = {32{rm[31]}}, C = rm[31].
- ROR:
  - amt[4:0] = 0 (amt = 32, 64, …): `op_b` = rm, C = rm[31].
  - otherwise: rotate by amt[4:0], C = rm[amt[4:0]-1].

Width rules:
- All intermediates are computed in 33 bits or less.
- An amount ≥ 32 never reaches a native shift operator; it is handled by the explicit cases above.

## Timing
- Reset values: state IDLE, `op_b` = 0, `carry_out` = 0, `valid` = 0, `busy` = 0, all latches 0.
- Immediate forms have a latency of 1: `start` at edge k gives `valid`/`op_b` after edge k. All inputs are sampled at edge k.
- `SRC_REG_REG` has a latency of 2:
  - `busy` = 1 after edge k;
  - `valid` = 1 and `busy` = 0 after edge k+1;
  - inputs may change after edge k.
- `op_b`/`carry_out` hold their value between `valid` pulses, since the ALU reads the held value.
- Reset asserted in SHIFT: the next state is IDLE, outputs are cleared, and no `valid` is produced.
- `carry_in` for `SRC_REG_REG` is the value sampled at the start edge; later CPSR changes are ignored.

## Structure
- Add `shift_type_t` and `shift_src_t` to `cpu_types_pkg`.
- Natural sub-module: `barrel_shift_core`, purely combinational. It takes (type, amount[7:0], amount_is_imm, value, carry_in) and returns {result, carry}. It is shared by the IDLE path and the SHIFT path.
- The wrapper holds the FSM, the latches and the output registers.

## Test plan
- `SRC_REG_IMM` LSL #4, rm = 0x1000_000F, cin = 0 → `op_b` = 0x0000_00F0, C = 1, `valid` 1 cycle after `start`.
- `SRC_REG_IMM` ROR #0 (RRX), rm = 0x0000_0003, cin = 1 → `op_b` = 0x8000_0001, C = 1.
- `SRC_REG_REG` LSR, rs = 0x0000_0120 (amt 32), rm = 0x8000_0000 → `busy` for 1 cycle, `valid` at the 2nd edge, `op_b` = 0, C = 1. Repeat with rs = 0x21 → `op_b` = 0, C = 0.
- `SRC_REG_REG` ROR, amt = 0x40, rm = 0x8000_0001 → `op_b` = 0x8000_0001, C = 1. Repeat with amt = 0, cin = 0 → `op_b` = rm, C = 0.
- `SRC_IMM_ROT` imm8 = 0xFF, rot4 = 4 → `op_b` = 0xFF00_0000, C = 1. Repeat with rot4 = 0, cin = 0 → `op_b` = 0x0000_00FF, C = 0.
- `start` pulsed again during SHIFT → ignored, exactly one `valid`. Separately, reset asserted in SHIFT → next cycle `busy` = 0, `valid` = 0, `op_b` = 0.
